// File: rtl/fetch_queue.sv
// Instruction prefetch queue: fetches sequentially from PC into a small circular buffer
// feeding decode, with execute-stage redirect, flush and misaligned-target halt.
module fetch_queue #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic [XLEN-1:0]            imem_addr,
    output logic                       imem_req,
    input  logic                       imem_ready,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       PCSrcE,
    input  logic [XLEN-1:0]            PCResultE,
    input  logic                       StallD,
    output logic                       ValidD,
    output logic [XLEN-1:0]            InstrD,
    output logic [XLEN-1:0]            PCD,
    output logic [XLEN-1:0]            PCPlus4D,
    output logic [$clog2(DEPTH+1)-1:0] CountF,
    output logic                       MisalignF
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

    typedef enum logic {
        StFetch,
        StHalted
    } stateT;

    stateT             stateQ, stateNext;
    logic [XLEN-1:0]   pcQ, pcNext;
    logic [PtrW-1:0]   rdPtrQ, rdPtrNext;
    logic [PtrW-1:0]   wrPtrQ, wrPtrNext;
    logic [CntW-1:0]   countQ, countNext;
    logic              misalignQ, misalignNext;

    logic [XLEN-1:0]   pcMem    [DEPTH];
    logic [XLEN-1:0]   instrMem [DEPTH];

    logic              push;
    logic              pop;

    // Gating with reset keeps the request low while reset is held.
    assign imem_req  = reset && (stateQ == StFetch) && (countQ != FullCount) && !PCSrcE;
    assign imem_addr = pcQ;
    assign push      = imem_req && imem_ready;
    assign pop       = ValidD && !StallD && !PCSrcE;

    assign ValidD    = (countQ != '0);
    assign InstrD    = ValidD ? instrMem[rdPtrQ] : '0;
    assign PCD       = ValidD ? pcMem[rdPtrQ] : '0;
    assign PCPlus4D  = ValidD ? (pcMem[rdPtrQ] + XLEN'(4)) : '0;
    assign CountF    = countQ;
    assign MisalignF = misalignQ;

    always_comb begin
        stateNext    = stateQ;
        pcNext       = pcQ;
        rdPtrNext    = rdPtrQ;
        wrPtrNext    = wrPtrQ;
        countNext    = countQ;
        misalignNext = misalignQ;

        if (PCSrcE) begin
            // Redirect flushes everything and overrides any concurrent pop.
            pcNext       = PCResultE;
            rdPtrNext    = '0;
            wrPtrNext    = '0;
            countNext    = '0;
            misalignNext = |PCResultE[1:0];
            stateNext    = (|PCResultE[1:0]) ? StHalted : StFetch;
        end else begin
            if (push) begin
                wrPtrNext = wrPtrQ + PtrW'(1);
                pcNext    = pcQ + XLEN'(4);
            end
            if (pop) begin
                rdPtrNext = rdPtrQ + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   countNext = countQ + CntW'(1);
                2'b01:   countNext = countQ - CntW'(1);
                default: countNext = countQ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateQ    <= StFetch;
            pcQ       <= RESET_PC;
            rdPtrQ    <= '0;
            wrPtrQ    <= '0;
            countQ    <= '0;
            misalignQ <= 1'b0;
        end else begin
            stateQ    <= stateNext;
            pcQ       <= pcNext;
            rdPtrQ    <= rdPtrNext;
            wrPtrQ    <= wrPtrNext;
            countQ    <= countNext;
            misalignQ <= misalignNext;
        end
    end

    // Payload storage needs no reset: outputs are masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            pcMem[wrPtrQ]    <= pcQ;
            instrMem[wrPtrQ] <= imem_rdata;
        end
    end

endmodule
